// File: rtl/nn_pkg.sv
// Shared constants and types for the neuron-layer sequencer and its datapath.
package nn_pkg;

  localparam int DATA_W    = 17;
  localparam int N_INPUTS  = 14;
  localparam int TRK_IDX_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic                 valid;
    logic [TRK_IDX_W-1:0] idx;
  } trk_entry_t;

endpackage

// File: rtl/valid_tracker.sv
// Shift register of {valid, idx} entries that mirrors the datapath latency.
// pending_o reports a live entry anywhere except the output stage.
module valid_tracker
  import nn_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 push_valid_i,
  input  logic [TRK_IDX_W-1:0] push_idx_i,
  output logic                 out_valid_o,
  output logic [TRK_IDX_W-1:0] out_idx_o,
  output logic                 pending_o
);

  trk_entry_t [DEPTH-1:0] stage_q, stage_d;

  always_comb begin
    stage_d = stage_q;
    if (clr_i) begin
      stage_d = '0;
    end else begin
      stage_d[0] = '{valid: push_valid_i, idx: push_idx_i};
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // When only the output stage holds a live entry, the last write is happening now.
  always_comb begin
    pending_o = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      pending_o = pending_o | stage_q[i].valid;
    end
  end

  assign out_valid_o = stage_q[DEPTH-1].valid;
  assign out_idx_o   = stage_q[DEPTH-1].idx;

endmodule

// File: rtl/neuron_layer_seq.sv
// Issues one neuron per cycle to the shared pipelined datapath and writes results back in order.
// Optional macro NEURON_SEQ_STATS_EN adds a saturating run-length counter on run_cycles_o.
module neuron_layer_seq
  import nn_pkg::*;
#(
  parameter int N_NEURONS = 10,
  parameter int ADDR_W    = 4,
  parameter int PIPE_LAT  = 7
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic [N_INPUTS*DATA_W-1:0]   x_in_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [ADDR_W-1:0]            w_addr_o,
  output logic [N_INPUTS*DATA_W-1:0]   dp_x_o,
  output logic                         dp_ce_o,
  input  logic [DATA_W-1:0]            dp_y_i,
  output logic                         res_we_o,
  output logic [ADDR_W-1:0]            res_addr_o,
  output logic [DATA_W-1:0]            res_data_o
`ifdef NEURON_SEQ_STATS_EN
  ,
  output logic [15:0]                  run_cycles_o
`endif
);

  localparam int                DEPTH    = 1 + PIPE_LAT;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_NEURONS - 1);

  seq_state_t                 state_q, state_d;
  logic [ADDR_W-1:0]          w_addr_q, w_addr_d;
  logic [N_INPUTS*DATA_W-1:0] dp_x_q, dp_x_d;
  logic                       start_acc;
  logic                       trk_clr;
  logic                       push_valid;
  logic [TRK_IDX_W-1:0]       push_idx;
  logic                       trk_valid;
  logic [TRK_IDX_W-1:0]       trk_idx;
  logic                       trk_pending;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      w_addr_q <= '0;
      dp_x_q   <= '0;
    end else begin
      state_q  <= state_d;
      w_addr_q <= w_addr_d;
      dp_x_q   <= dp_x_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    w_addr_d   = w_addr_q;
    dp_x_d     = dp_x_q;
    start_acc  = 1'b0;
    trk_clr    = 1'b0;
    push_valid = 1'b0;
    push_idx   = '0;
    unique case (state_q)
      IDLE: begin
        w_addr_d = '0;
        if (start_i && !abort_i) begin
          start_acc = 1'b1;
          state_d   = ISSUE;
          dp_x_d    = x_in_i;
        end
      end
      ISSUE: begin
        push_valid = 1'b1;
        push_idx   = TRK_IDX_W'(w_addr_q);
        if (abort_i) begin
          state_d  = IDLE;
          w_addr_d = '0;
          trk_clr  = 1'b1;
        end else if (w_addr_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          w_addr_d = w_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (abort_i) begin
          state_d  = IDLE;
          w_addr_d = '0;
          trk_clr  = 1'b1;
        end else if (!trk_pending) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d  = IDLE;
        w_addr_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  valid_tracker #(
    .DEPTH(DEPTH)
  ) u_tracker (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (trk_clr),
    .push_valid_i(push_valid),
    .push_idx_i  (push_idx),
    .out_valid_o (trk_valid),
    .out_idx_o   (trk_idx),
    .pending_o   (trk_pending)
  );

  assign busy_o     = (state_q == ISSUE) || (state_q == DRAIN);
  assign done_o     = (state_q == DONE);
  assign dp_ce_o    = (state_q != IDLE);
  assign w_addr_o   = w_addr_q;
  assign dp_x_o     = dp_x_q;
  assign res_we_o   = trk_valid;
  assign res_addr_o = ADDR_W'(trk_idx);
  assign res_data_o = dp_y_i;

`ifdef NEURON_SEQ_STATS_EN
  logic [15:0] run_cycles_q, run_cycles_d;

  always_comb begin
    run_cycles_d = run_cycles_q;
    if (start_acc) begin
      run_cycles_d = '0;
    end else if (busy_o && (run_cycles_q != 16'hFFFF)) begin
      run_cycles_d = run_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_cycles_q <= '0;
    end else begin
      run_cycles_q <= run_cycles_d;
    end
  end

  assign run_cycles_o = run_cycles_q;
`endif

endmodule

// File: tb/tb_neuron_layer_seq.sv
// Bench for neuron_layer_seq: two instances (10 neurons and 1 neuron) driven by scenario tables
// and random runs, compared cycle by cycle against a run-level timing model.
module tb_neuron_layer_seq;
  import nn_pkg::*;

  localparam int P    = 7;
  localparam int AW   = 4;
  localparam int XW   = N_INPUTS * DATA_W;
  localparam int MAXC = 64;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  logic          start0, abort0, start1, abort1;
  logic [XW-1:0] xIn0, xIn1;
  logic          busy0, done0, dpCe0, resWe0, busy1, done1, dpCe1, resWe1;
  logic [AW-1:0] wAddr0, resAddr0, wAddr1, resAddr1;
  logic [XW-1:0] dpX0, dpX1;
  logic [DATA_W-1:0] dpY0, resData0, dpY1, resData1;
`ifdef NEURON_SEQ_STATS_EN
  logic [15:0] runCycles0, runCycles1;
`endif

  neuron_layer_seq #(.N_NEURONS(10), .ADDR_W(AW), .PIPE_LAT(P)) dut (
    .clk_i(clk), .rst_ni(rstN), .start_i(start0), .abort_i(abort0), .x_in_i(xIn0),
    .busy_o(busy0), .done_o(done0), .w_addr_o(wAddr0), .dp_x_o(dpX0), .dp_ce_o(dpCe0),
    .dp_y_i(dpY0), .res_we_o(resWe0), .res_addr_o(resAddr0), .res_data_o(resData0)
`ifdef NEURON_SEQ_STATS_EN
    , .run_cycles_o(runCycles0)
`endif
  );

  neuron_layer_seq #(.N_NEURONS(1), .ADDR_W(AW), .PIPE_LAT(P)) dut1 (
    .clk_i(clk), .rst_ni(rstN), .start_i(start1), .abort_i(abort1), .x_in_i(xIn1),
    .busy_o(busy1), .done_o(done1), .w_addr_o(wAddr1), .dp_x_o(dpX1), .dp_ce_o(dpCe1),
    .dp_y_i(dpY1), .res_we_o(resWe1), .res_addr_o(resAddr1), .res_data_o(resData1)
`ifdef NEURON_SEQ_STATS_EN
    , .run_cycles_o(runCycles1)
`endif
  );

  // Environment: ROM holds weight = address, datapath returns yBase + weight after P enabled cycles.
  int unsigned       yBase;
  logic [AW-1:0]     romQ0, romQ1;
  logic [DATA_W-1:0] pipe0 [P];
  logic [DATA_W-1:0] pipe1 [P];

  always @(posedge clk) begin
    romQ0 <= wAddr0;
    romQ1 <= wAddr1;
    if (dpCe0) begin
      pipe0[0] <= DATA_W'(yBase + 32'(romQ0));
      for (int i = 1; i < P; i++) pipe0[i] <= pipe0[i-1];
    end
    if (dpCe1) begin
      pipe1[0] <= DATA_W'(yBase + 32'(romQ1));
      for (int i = 1; i < P; i++) pipe1[i] <= pipe1[i-1];
    end
  end
  assign dpY0 = pipe0[P-1];
  assign dpY1 = pipe1[P-1];

  int curSel = 0;
  logic              sBusy, sDone, sCe, sWe;
  logic [AW-1:0]     sWaddr, sAddr;
  logic [XW-1:0]     sDpx;
  logic [DATA_W-1:0] sData, sDpy;
  assign sBusy  = (curSel == 1) ? busy1    : busy0;
  assign sDone  = (curSel == 1) ? done1    : done0;
  assign sCe    = (curSel == 1) ? dpCe1    : dpCe0;
  assign sWe    = (curSel == 1) ? resWe1   : resWe0;
  assign sWaddr = (curSel == 1) ? wAddr1   : wAddr0;
  assign sAddr  = (curSel == 1) ? resAddr1 : resAddr0;
  assign sDpx   = (curSel == 1) ? dpX1     : dpX0;
  assign sData  = (curSel == 1) ? resData1 : resData0;
  assign sDpy   = (curSel == 1) ? dpY1     : dpY0;

  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Per-cycle log of the selected instance, indexed by cycle relative to scenario start.
  int cyc = 0;
  int baseCyc = 0;
  bit logging = 1'b0;
  logic              logWe [MAXC], logDone [MAXC], logBusy [MAXC], logCe [MAXC];
  logic [AW-1:0]     logAddr [MAXC], logWaddr [MAXC];
  logic [DATA_W-1:0] logData [MAXC];
  logic [XW-1:0]     logDpx [MAXC];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int r;
    r = cyc - baseCyc;
    if (logging && r >= 0 && r < MAXC) begin
      logWe[r] = sWe;  logAddr[r] = sAddr;   logData[r] = sData;
      logDone[r] = sDone; logBusy[r] = sBusy; logCe[r] = sCe;
      logWaddr[r] = sWaddr; logDpx[r] = sDpx;
    end
  end

  // Scenario description shared by stimulus, model and checker.
  int            stNStarts, stAbort, stRst, stLen;
  int            stStarts [4];
  logic [XW-1:0] stX [4];

  // Expected values: expWe 2 marks a write that may or may not happen (abort cycle).
  int            expWe [MAXC], expAddr [MAXC], expData [MAXC];
  int            expDone [MAXC], expBusy [MAXC], expCe [MAXC], expWaddr [MAXC];
  logic [XW-1:0] expDpx [MAXC];
  int            expRun;
  bit            anyRun;

  task automatic buildModel();
    int n, free, s, lastBusy, doneC, cut, cutKind, wc;
    n = (curSel == 1) ? 1 : 10;
    for (int r = 0; r < MAXC; r++) begin
      expWe[r] = 0; expAddr[r] = 0; expData[r] = 0; expDone[r] = 0;
      expBusy[r] = 0; expCe[r] = 0; expWaddr[r] = 0; expDpx[r] = '0;
    end
    free = 0; expRun = 0; anyRun = 1'b0;
    for (int i = 0; i < stNStarts; i++) begin
      s = stStarts[i];
      if (s < free || s == stAbort || s == stRst) continue;
      lastBusy = s + n + 1 + P;
      doneC    = lastBusy + 1;
      cutKind  = 0;
      cut      = 1000;
      if (stAbort > s && stAbort <= lastBusy) begin cutKind = 1; cut = stAbort; end
      if (stRst > s && stRst <= doneC && stRst < cut) begin cutKind = 2; cut = stRst; end
      for (int c = s + 1; c <= lastBusy && c < MAXC; c++) begin
        if ((cutKind == 1 && c > cut) || (cutKind == 2 && c >= cut)) break;
        expBusy[c] = 1; expCe[c] = 1; expDpx[c] = stX[i];
        expWaddr[c] = (c - s - 1 < n - 1) ? c - s - 1 : n - 1;
      end
      for (int k = 0; k < n; k++) begin
        wc = s + 2 + P + k;
        if (wc >= MAXC) break;
        if ((cutKind == 1 && wc > cut) || (cutKind == 2 && wc >= cut)) break;
        if (cutKind == 1 && wc == cut) expWe[wc] = 2;
        else begin
          expWe[wc] = 1; expAddr[wc] = k; expData[wc] = int'(yBase) + k;
        end
      end
      anyRun = 1'b1;
      if (cutKind == 0) begin
        if (doneC < MAXC) begin
          expDone[doneC] = 1; expCe[doneC] = 1; expWaddr[doneC] = n - 1;
        end
        free = doneC + 1; expRun = n + 1 + P;
      end else if (cutKind == 1) begin
        free = cut + 1; expRun = cut - s;
      end else begin
        free = cut + 1; expRun = 0;
      end
    end
  endtask

  task automatic applyStimulus();
    for (int rel = 0; rel < stLen; rel++) begin
      @(posedge clk); #1;
      if (rel == 0) begin baseCyc = cyc; logging = 1'b1; end
      start0 = 1'b0; start1 = 1'b0; abort0 = 1'b0; abort1 = 1'b0;
      xIn0 = {8{$urandom}}; xIn1 = {8{$urandom}};
      for (int i = 0; i < stNStarts; i++) begin
        if (stStarts[i] == rel) begin
          if (curSel == 1) begin start1 = 1'b1; xIn1 = stX[i]; end
          else begin start0 = 1'b1; xIn0 = stX[i]; end
        end
      end
      if (rel == stAbort) begin
        if (curSel == 1) abort1 = 1'b1; else abort0 = 1'b1;
      end
      rstN = (rel == stRst) ? 1'b0 : 1'b1;
      if (rel == stRst) begin
        @(negedge clk);
        checkVal("rst busy", 256'(sBusy), 256'(0));
        checkVal("rst done", 256'(sDone), 256'(0));
        checkVal("rst w_addr", 256'(sWaddr), 256'(0));
        checkVal("rst dp_x", 256'(sDpx), 256'(0));
        checkVal("rst dp_ce", 256'(sCe), 256'(0));
        checkVal("rst res_we", 256'(sWe), 256'(0));
        checkVal("rst res_addr", 256'(sAddr), 256'(0));
        checkVal("rst res_data", 256'(sData), 256'(sDpy));
      end
    end
    @(posedge clk); #1;
    logging = 1'b0;
    start0 = 1'b0; start1 = 1'b0; abort0 = 1'b0; abort1 = 1'b0; rstN = 1'b1;
  endtask

  task automatic checkOutput(input int minW, input int maxW, input int expDones);
    int nW, nD;
    nW = 0; nD = 0;
    for (int r = 0; r < stLen; r++) begin
      if (expWe[r] != 2) begin
        checkVal($sformatf("res_we c%0d", r), 256'(logWe[r]), 256'(expWe[r]));
        if (expWe[r] == 1) begin
          checkVal($sformatf("res_addr c%0d", r), 256'(logAddr[r]), 256'(expAddr[r]));
          checkVal($sformatf("res_data c%0d", r), 256'(logData[r]), 256'(expData[r]));
        end
      end
      if (logWe[r] === 1'b1) nW++;
      if (logDone[r] === 1'b1) nD++;
      checkVal($sformatf("done c%0d", r), 256'(logDone[r]), 256'(expDone[r]));
      checkVal($sformatf("busy c%0d", r), 256'(logBusy[r]), 256'(expBusy[r]));
      checkVal($sformatf("dp_ce c%0d", r), 256'(logCe[r]), 256'(expCe[r]));
      checkVal($sformatf("w_addr c%0d", r), 256'(logWaddr[r]), 256'(expWaddr[r]));
      if (expBusy[r] == 1) checkVal($sformatf("dp_x c%0d", r), 256'(logDpx[r]), 256'(expDpx[r]));
    end
    if (minW >= 0) begin
      checks++;
      if (nW < minW || nW > maxW) begin
        errors++;
        $display("[TB] FAIL write count: got %0d, want %0d..%0d", nW, minW, maxW);
      end
      checkVal("done count", 256'(nD), 256'(expDones));
    end
`ifdef NEURON_SEQ_STATS_EN
    if (stRst < 0 && anyRun)
      checkVal("run_cycles", 256'((curSel == 1) ? runCycles1 : runCycles0), 256'(expRun));
`endif
  endtask

  typedef struct {
    int sel;
    int nStarts;
    int starts [4];
    int abortAt;
    int rstAt;
    int len;
    int minW;
    int maxW;
    int dones;
  } vecT;

  vecT vecs [7];

  initial begin
    vecs[0] = '{0, 4, '{0, 3, 19, 20}, -1, -1, 45, 20, 20, 2};
    vecs[1] = '{0, 1, '{0, 0, 0, 0},   12, -1, 25, 3, 4, 0};
    vecs[2] = '{0, 1, '{0, 0, 0, 0},   -1,  5, 25, 0, 0, 0};
    vecs[3] = '{1, 1, '{0, 0, 0, 0},   -1, -1, 15, 1, 1, 1};
    vecs[4] = '{0, 1, '{2, 0, 0, 0},    2, -1, 20, 0, 0, 0};
    vecs[5] = '{0, 1, '{0, 0, 0, 0},   19, -1, 25, 10, 10, 1};
    vecs[6] = '{1, 4, '{0, 5, 10, 11}, -1, -1, 25, 2, 2, 2};

    rstN = 1'b0; yBase = 100;
    start0 = 1'b0; start1 = 1'b0; abort0 = 1'b0; abort1 = 1'b0;
    xIn0 = '0; xIn1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("init busy", 256'(busy0), 256'(0));
    checkVal("init done", 256'(done0), 256'(0));
    checkVal("init w_addr", 256'(wAddr0), 256'(0));
    checkVal("init dp_x", 256'(dpX0), 256'(0));
    checkVal("init dp_ce", 256'(dpCe0), 256'(0));
    checkVal("init res_we", 256'(resWe0), 256'(0));
    @(posedge clk); #1;
    rstN = 1'b1;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 7; v++) begin
      curSel = vecs[v].sel;
      stNStarts = vecs[v].nStarts;
      for (int i = 0; i < 4; i++) begin
        stStarts[i] = vecs[v].starts[i];
        stX[i] = {8{$urandom}};
      end
      stAbort = vecs[v].abortAt; stRst = vecs[v].rstAt; stLen = vecs[v].len;
      yBase = 100;
      applyStimulus();
      buildModel();
      checkOutput(vecs[v].minW, vecs[v].maxW, vecs[v].dones);
      repeat (2) @(posedge clk);
    end

    for (int it = 0; it < 16; it++) begin
      curSel = int'($urandom_range(1, 0));
      stNStarts = int'($urandom_range(3, 1));
      stStarts[0] = int'($urandom_range(10, 0));
      for (int i = 1; i < 4; i++) stStarts[i] = stStarts[i-1] + int'($urandom_range(15, 1));
      for (int i = 0; i < 4; i++) stX[i] = {8{$urandom}};
      stAbort = ($urandom_range(1, 0) == 1) ? int'($urandom_range(45, 0)) : -1;
      stRst = -1; stLen = 60;
      yBase = $urandom_range(60000, 0);
      applyStimulus();
      buildModel();
      checkOutput(-1, -1, 0);
      repeat (2) @(posedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_layer_seq.md
# neuron_layer_seq

Sequencer that time-multiplexes one pipelined 14-input neuron datapath (multipliers, adder tree, sigmoid LUT) across all neurons of a layer. On `start` it latches the input vector and issues one neuron per cycle by stepping the weight-ROM address. It tracks datapath latency with a valid/index shift register and writes each neuron output into the layer result buffer. It sits between the network top-level FSM and the shared neuron datapath.

## Interface
- `N_NEURONS`, 10: neurons in the layer; legal range 1..2^ADDR_W.
- `ADDR_W`, 4: width of the weight-ROM and result-buffer address.
- `PIPE_LAT`, 7: cycles from datapath `x`/`w` valid to `y` valid (`ce` held high).
- `DATA_W`, 17: fixed-point word width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; ignored unless in IDLE.
- `abort` in 1: synchronous cancel of a run.
- `x_in` in 14*DATA_W: layer input vector, sampled on the accepted `start`.
- `busy` out 1: high in ISSUE and DRAIN.
- `done` out 1: one-cycle pulse after the last result is written.
- `w_addr` out ADDR_W: weight-ROM address; ROM is synchronous with 1-cycle read latency.
- `dp_x` out 14*DATA_W: latched input vector to the datapath.
- `dp_ce` out 1: datapath clock enable.
- `dp_y` in DATA_W: datapath output.
- `res_we` out 1: result-buffer write strobe.
- `res_addr` out ADDR_W: result-buffer address (neuron index).
- `res_data` out DATA_W: equals `dp_y` in the cycle `res_we` is high.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE → ISSUE on `start`:
  - latch `x_in` into `dp_x`;
  - clear the issue counter;
  - set `w_addr` = 0.
- ISSUE:
  - each cycle, push {valid=1, idx=`w_addr`} into the tracking shift register, then increment `w_addr`;
  - after index N_NEURONS-1 is issued, go to DRAIN.
- DRAIN: push valid=0 entries until the tracking register is empty, then go to DONE.
- DONE: assert `done` for one cycle, then return to IDLE.
- Tracking register depth is 1+PIPE_LAT: 1 cycle of ROM latency plus PIPE_LAT of datapath.
- At the register output, if valid=1: `res_we`=1, `res_addr`=idx, `res_data`=`dp_y`.
- `dp_ce` is 1 in ISSUE, DRAIN and DONE, and 0 in IDLE.
- `dp_x` is held constant for the whole run. It changes only on an accepted `start`.
- `start` during busy or DONE is ignored; no queuing.
- `abort` in ISSUE or DRAIN:
  - next state is IDLE;
  - all tracking valid bits are cleared;
  - no further `res_we` and no `done`.
- `abort` in IDLE has no effect.
- `abort` and `start` together in IDLE: `abort` wins and the run does not start.
- `w_addr` never exceeds N_NEURONS-1. It holds its last value in DRAIN and DONE and returns to 0 in IDLE.
- Reset values of every output: `busy`=0, `done`=0, `w_addr`=0, `dp_x`=0, `dp_ce`=0, `res_we`=0, `res_addr`=0, `res_data`=`dp_y` (combinational pass-through). Tracking valid bits are all 0 and the state is IDLE.
- Reset asserted mid-run ends the run immediately, with no `done` and no further writes.

## Timing
- `start` accepted at cycle 0 → ISSUE from cycle 1; `w_addr`=k at cycle 1+k.
- Write of index k occurs at cycle 1+k+1+PIPE_LAT, so the first write is at cycle 2+PIPE_LAT.
- The last write is at cycle N_NEURONS+1+PIPE_LAT. `done` pulses in the following cycle, at N_NEURONS+2+PIPE_LAT.
- Writes are back-to-back, one per cycle, in index order with no gaps.
- `busy` is high from cycle 1 through the last-write cycle inclusive.
- The next `start` is accepted no earlier than the cycle after `done`.

## Configuration
- Macro `NEURON_SEQ_STATS_EN`.
- Defined: adds output `run_cycles` [15:0].
  - Cleared on an accepted `start`.
  - Increments every cycle while `busy`, saturating at 16'hFFFF.
  - Holds after `done` or `abort`.
  - Reset value 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `nn_pkg` holds:
  - `DATA_W` and `N_INPUTS`=14;
  - the state typedef `seq_state_t`;
  - the tracking-entry typedef {valid, idx}.
- One natural sub-module, `valid_tracker`: a parameterised-depth shift register of {valid, idx} with synchronous clear (used by `abort`) and async reset.

## Test plan
- N_NEURONS=10, PIPE_LAT=7, single `start` → writes idx 0..9 at cycles 9..18, `done` at cycle 19, `busy` high cycles 1..18.
- Datapath model returning y = 100+idx → buffer contains 100..109, and `dp_x` equals the sampled `x_in` throughout the run.
- `start` re-pulsed at cycles 3 and 19 → both ignored; a third `start` at cycle 20 starts a new run with writes beginning at cycle 29.
- `abort` at cycle 12 → writes for idx 0..3 only (cycles 9..12 inclusive are not guaranteed; require no `res_we` after cycle 12), no `done`, state IDLE at cycle 13.
- `rst_n` low at cycle 5 → all outputs at their reset values in the same cycle; no writes or `done` after release.
- N_NEURONS=1 edge case → single write at cycle 9, `done` at cycle 10; with `NEURON_SEQ_STATS_EN`, `run_cycles`=9 after `done`.
